// File: rtl/axilm_rd_pipe.sv
// AXI4-Lite read master with a single AR register slot, a credit counter that
// bounds reads in flight, and an in-order response FIFO towards the local side.
module axilm_rd_pipe #(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned MAX_OUTST = 4,
    parameter int unsigned CNT_W     = $clog2(MAX_OUTST + 1)
) (
    input  logic              ACLK,
    input  logic              ARESETn,
    // AXI4-Lite read address channel
    output logic [ADDR_W-1:0] ARADDR,
    output logic [2:0]        ARPROT,
    output logic              ARVALID,
    input  logic              ARREADY,
    // AXI4-Lite read data channel
    input  logic [DATA_W-1:0] RDATA,
    input  logic [1:0]        RRESP,
    input  logic              RVALID,
    output logic              RREADY,
    // Local request side
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [2:0]        req_prot,
    // Local response side
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic [1:0]        rsp_resp,
    // Status
    output logic [CNT_W-1:0]  inflight,
    output logic              busy
);

    localparam int unsigned PTR_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
    localparam int unsigned ENT_W = DATA_W + 2;

    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_OUTST);
    localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MAX_OUTST - 1);
    localparam logic [PTR_W-1:0] ONE_PTR  = PTR_W'(1);

    // Reject illegal parameterisations at elaboration time.
    if (MAX_OUTST < 1 || MAX_OUTST > 16) begin : g_bad_outst
        $error("axilm_rd_pipe: MAX_OUTST must be within 1..16");
    end
    if (DATA_W != 32 && DATA_W != 64) begin : g_bad_data_w
        $error("axilm_rd_pipe: DATA_W must be 32 or 64");
    end
    if (CNT_W != $clog2(MAX_OUTST + 1)) begin : g_bad_cnt_w
        $error("axilm_rd_pipe: CNT_W is derived and must not be overridden");
    end

    // ------------------------------------------------------------------
    // Handshake qualifiers
    // ------------------------------------------------------------------
    logic              credit_ok;
    logic              accept;
    logic              push;
    logic              pop;

    // AR slot state
    logic              ar_valid_q, ar_valid_d;
    logic [ADDR_W-1:0] ar_addr_q,  ar_addr_d;
    logic [2:0]        ar_prot_q,  ar_prot_d;

    // Credit counter
    logic [CNT_W-1:0]  inflight_q, inflight_d;

    // Response FIFO state
    logic [ENT_W-1:0]  mem [MAX_OUTST];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_inc;
    logic [PTR_W-1:0]  rd_ptr_inc;
    logic [CNT_W-1:0]  count_q,  count_d;
    logic [ENT_W-1:0]  wr_entry;

    // Registered FIFO-derived outputs
    logic              rready_q,    rready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [ENT_W-1:0]  head_q,      head_d;

    // Credits count everything accepted locally but not yet popped, so the FIFO
    // can never hold more than MAX_OUTST entries and never overflows.
    assign credit_ok = (inflight_q < MAX_CNT);
    // Combinational through ARREADY so the slot refills in the cycle it drains.
    assign req_ready = credit_ok & (~ar_valid_q | ARREADY);
    assign accept    = req_valid & req_ready;
    assign push      = RVALID & rready_q;
    assign pop       = rsp_valid_q & rsp_ready;
    assign wr_entry  = {RRESP, RDATA};

    // ------------------------------------------------------------------
    // AR slot
    // ------------------------------------------------------------------

    // Next-state for the AR slot: load on accept, drop once the slave takes it.
    always_comb begin
        ar_valid_d = ar_valid_q;
        ar_addr_d  = ar_addr_q;
        ar_prot_d  = ar_prot_q;
        if (accept) begin
            ar_valid_d = 1'b1;
            ar_addr_d  = req_addr;
            ar_prot_d  = req_prot;
        end else if (ar_valid_q && ARREADY) begin
            ar_valid_d = 1'b0;
        end
    end

    // AR slot registers.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            ar_valid_q <= 1'b0;
            ar_addr_q  <= '0;
            ar_prot_q  <= '0;
        end else begin
            ar_valid_q <= ar_valid_d;
            ar_addr_q  <= ar_addr_d;
            ar_prot_q  <= ar_prot_d;
        end
    end

    // ------------------------------------------------------------------
    // In-flight counter
    // ------------------------------------------------------------------

    // Next-state for the credit counter; accept and pop together cancel out.
    always_comb begin
        inflight_d = inflight_q;
        unique case ({accept, pop})
            2'b10:   inflight_d = inflight_q + ONE_CNT;
            2'b01:   inflight_d = inflight_q - ONE_CNT;
            default: inflight_d = inflight_q;
        endcase
    end

    // Credit counter register.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            inflight_q <= '0;
        end else begin
            inflight_q <= inflight_d;
        end
    end

    // ------------------------------------------------------------------
    // Response FIFO
    // ------------------------------------------------------------------

    // Pointer increments wrap explicitly since the depth need not be a power of two.
    always_comb begin
        wr_ptr_inc = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + ONE_PTR;
        rd_ptr_inc = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + ONE_PTR;
    end

    // Next-state for FIFO pointers, occupancy and the registered head/flags.
    always_comb begin
        wr_ptr_d = push ? wr_ptr_inc : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_inc : rd_ptr_q;

        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + ONE_CNT;
            2'b01:   count_d = count_q - ONE_CNT;
            default: count_d = count_q;
        endcase

        // Head tracks the entry that will sit at rd_ptr_d; when the FIFO is (or
        // is about to be) empty, the incoming R beat bypasses straight into it.
        head_d = head_q;
        if (pop) begin
            if (count_q > ONE_CNT) begin
                head_d = mem[rd_ptr_inc];
            end else if (push) begin
                head_d = wr_entry;
            end
        end else if ((count_q == '0) && push) begin
            head_d = wr_entry;
        end

        rready_d    = (count_d != MAX_CNT);
        rsp_valid_d = (count_d != '0);
    end

    // FIFO control registers; RREADY comes up one cycle after reset release.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            head_q      <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            rready_q    <= rready_d;
            rsp_valid_q <= rsp_valid_d;
            head_q      <= head_d;
        end
    end

    // FIFO storage; contents are qualified by the pointers, so no reset needed.
    always_ff @(posedge ACLK) begin
        if (push) begin
            mem[wr_ptr_q] <= wr_entry;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign ARVALID   = ar_valid_q;
    assign ARADDR    = ar_addr_q;
    assign ARPROT    = ar_prot_q;
    assign RREADY    = rready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_resp  = head_q[ENT_W-1 -: 2];
    assign rsp_data  = head_q[DATA_W-1:0];
    assign inflight  = inflight_q;
    assign busy      = (inflight_q != '0) | ar_valid_q;

endmodule

// File: tb/tb_axilm_rd_pipe.sv
// Directed bench for axilm_rd_pipe with MAX_OUTST=4 and 32-bit address/data.
module tb_axilm_rd_pipe;

    localparam int unsigned ADDR_W    = 32;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned MAX_OUTST = 4;
    localparam int unsigned CNT_W     = $clog2(MAX_OUTST + 1);

    logic              ACLK;
    logic              ARESETn;
    logic [ADDR_W-1:0] ARADDR;
    logic [2:0]        ARPROT;
    logic              ARVALID;
    logic              ARREADY;
    logic [DATA_W-1:0] RDATA;
    logic [1:0]        RRESP;
    logic              RVALID;
    logic              RREADY;
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic [2:0]        req_prot;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic [1:0]        rsp_resp;
    logic [CNT_W-1:0]  inflight;
    logic              busy;

    int checks = 0;
    int errors = 0;
    int ar_hs  = 0;
    int ar_base;

    axilm_rd_pipe #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .MAX_OUTST (MAX_OUTST)
    ) dut (
        .ACLK      (ACLK),
        .ARESETn   (ARESETn),
        .ARADDR    (ARADDR),
        .ARPROT    (ARPROT),
        .ARVALID   (ARVALID),
        .ARREADY   (ARREADY),
        .RDATA     (RDATA),
        .RRESP     (RRESP),
        .RVALID    (RVALID),
        .RREADY    (RREADY),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_prot  (req_prot),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_resp  (rsp_resp),
        .inflight  (inflight),
        .busy      (busy)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    // Count AR handshakes seen on the bus.
    always @(posedge ACLK) begin
        if (ARVALID === 1'b1 && ARREADY === 1'b1) ar_hs <= ar_hs + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        #2;
    endtask

    initial begin
        ARESETn   = 1'b0;
        ARREADY   = 1'b0;
        RDATA     = '0;
        RRESP     = '0;
        RVALID    = 1'b0;
        req_valid = 1'b0;
        req_addr  = '0;
        req_prot  = '0;
        rsp_ready = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst_arvalid", ARVALID, 0);
        chk("rst_araddr", ARADDR, 0);
        chk("rst_rready", RREADY, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_inflight", inflight, 0);
        chk("rst_busy", busy, 0);
        #3 ARESETn = 1'b1;
        tick();
        chk("rready_after_release", RREADY, 1);

        // Single read: accept N, AR N+1, R N+2, rsp N+3
        req_valid = 1'b1; req_addr = 32'h0000_1000; req_prot = 3'd0; ARREADY = 1'b1;
        #1 chk("single_req_ready", req_ready, 1);
        tick();
        req_valid = 1'b0;
        chk("single_arvalid", ARVALID, 1);
        chk("single_araddr", ARADDR, 32'h1000);
        chk("single_inflight", inflight, 1);
        chk("single_busy", busy, 1);
        tick();
        chk("single_ar_drop", ARVALID, 0);
        chk("single_rsp_not_yet", rsp_valid, 0);
        RVALID = 1'b1; RDATA = 32'hDEAD_BEEF; RRESP = 2'd0;
        tick();
        RVALID = 1'b0;
        chk("single_rsp_valid", rsp_valid, 1);
        chk("single_rsp_data", rsp_data, 32'hDEAD_BEEF);
        chk("single_rsp_resp", rsp_resp, 0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("single_rsp_gone", rsp_valid, 0);
        chk("single_inflight_0", inflight, 0);
        chk("single_idle", busy, 0);

        // Outstanding limit: four back-to-back ARs, then no credit
        ar_base = ar_hs;
        for (int k = 0; k < 4; k++) begin
            req_valid = 1'b1; req_addr = 32'(4 * k);
            #1 chk("lim_req_ready", req_ready, 1);
            tick();
            chk("lim_arvalid", ARVALID, 1);
            chk("lim_araddr", ARADDR, 64'(4 * k));
        end
        req_addr = 32'h10;
        #1 chk("lim_no_credit", req_ready, 0);
        chk("lim_inflight_4", inflight, 4);
        tick();
        chk("lim_ar_idle", ARVALID, 0);
        chk("lim_no_credit2", req_ready, 0);
        tick();
        chk("lim_ar_idle2", ARVALID, 0);
        chk("lim_ar_count", 64'(ar_hs - ar_base), 4);
        req_valid = 1'b0;

        // Fill the FIFO with rsp_ready low
        RVALID = 1'b1; RRESP = 2'd0; RDATA = 32'h11; tick();
        RDATA = 32'h22; tick();
        RDATA = 32'h33; tick();
        RDATA = 32'h44; tick();
        RVALID = 1'b0;
        chk("full_rready", RREADY, 0);
        chk("full_rsp_valid", rsp_valid, 1);
        chk("full_head", rsp_data, 32'h11);
        tick();
        chk("full_rready_hold", RREADY, 0);
        chk("full_head_hold", rsp_data, 32'h11);

        // Drain in order; new credit appears the cycle after the first pop
        rsp_ready = 1'b1;
        chk("pop0", rsp_data, 32'h11);
        tick();
        chk("pop1", rsp_data, 32'h22);
        chk("pop1_rready", RREADY, 1);
        chk("pop1_inflight", inflight, 3);
        req_valid = 1'b1; req_addr = 32'h10;
        #1 chk("fifth_req_ready", req_ready, 1);
        tick();
        req_valid = 1'b0;
        chk("pop2", rsp_data, 32'h33);
        chk("fifth_arvalid", ARVALID, 1);
        chk("fifth_araddr", ARADDR, 32'h10);
        chk("pop2_inflight", inflight, 3);
        tick();
        chk("pop3", rsp_data, 32'h44);
        chk("pop3_valid", rsp_valid, 1);
        tick();
        rsp_ready = 1'b0;
        chk("drained", rsp_valid, 0);
        chk("drained_inflight", inflight, 1);
        RVALID = 1'b1; RDATA = 32'h55; tick();
        RVALID = 1'b0;
        chk("wrap_rsp_data", rsp_data, 32'h55);
        rsp_ready = 1'b1; tick();
        rsp_ready = 1'b0;
        chk("wrap_inflight_0", inflight, 0);

        // ARREADY stall: slot holds for five cycles
        ARREADY = 1'b0;
        ar_base = ar_hs;
        req_valid = 1'b1; req_addr = 32'h2000; req_prot = 3'b101;
        #1 chk("stall_accept", req_ready, 1);
        tick();
        req_addr = 32'h3000; req_prot = 3'b000;
        for (int i = 0; i < 5; i++) begin
            chk("stall_arvalid", ARVALID, 1);
            chk("stall_araddr", ARADDR, 32'h2000);
            chk("stall_arprot", ARPROT, 3'b101);
            #1 chk("stall_req_ready", req_ready, 0);
            tick();
        end
        req_valid = 1'b0; ARREADY = 1'b1;
        chk("stall_still_valid", ARVALID, 1);
        chk("stall_still_addr", ARADDR, 32'h2000);
        tick();
        chk("stall_ar_drop", ARVALID, 0);
        chk("stall_ar_count", 64'(ar_hs - ar_base), 1);
        chk("stall_inflight", inflight, 1);
        RVALID = 1'b1; RDATA = 32'h66; RRESP = 2'd0; tick();
        RVALID = 1'b0;
        chk("stall_rsp_data", rsp_data, 32'h66);
        rsp_ready = 1'b1; tick();
        rsp_ready = 1'b0;
        chk("stall_inflight_0", inflight, 0);

        // Error passthrough: RRESP=SLVERR on the middle read
        ar_base = ar_hs;
        for (int k = 0; k < 3; k++) begin
            req_valid = 1'b1; req_addr = 32'(32'h100 + 4 * k);
            tick();
        end
        req_valid = 1'b0;
        tick();
        tick();
        chk("err_ar_count", 64'(ar_hs - ar_base), 3);
        rsp_ready = 1'b1;
        RVALID = 1'b1; RDATA = 32'h1; RRESP = 2'b00; tick();
        chk("err_v0", rsp_valid, 1);
        chk("err_d0", rsp_data, 32'h1);
        chk("err_r0", rsp_resp, 2'b00);
        RDATA = 32'h2; RRESP = 2'b10; tick();
        chk("err_v1", rsp_valid, 1);
        chk("err_d1", rsp_data, 32'h2);
        chk("err_r1", rsp_resp, 2'b10);
        RDATA = 32'h3; RRESP = 2'b00; tick();
        chk("err_v2", rsp_valid, 1);
        chk("err_d2", rsp_data, 32'h3);
        chk("err_r2", rsp_resp, 2'b00);
        RVALID = 1'b0;
        tick();
        rsp_ready = 1'b0;
        chk("err_drained", rsp_valid, 0);
        chk("err_inflight_0", inflight, 0);
        chk("err_no_extra_ar", 64'(ar_hs - ar_base), 3);

        // Reset mid-operation: three in flight, ARVALID high, one response queued
        req_valid = 1'b1; req_addr = 32'h500; tick();
        req_addr = 32'h504; tick();
        req_addr = 32'h508; RVALID = 1'b1; RDATA = 32'h99; RRESP = 2'd0; tick();
        req_valid = 1'b0; RVALID = 1'b0; ARREADY = 1'b0;
        chk("mid_arvalid", ARVALID, 1);
        chk("mid_inflight", inflight, 3);
        chk("mid_rsp_valid", rsp_valid, 1);
        #2 ARESETn = 1'b0;
        #1;
        chk("arst_arvalid", ARVALID, 0);
        chk("arst_araddr", ARADDR, 0);
        chk("arst_arprot", ARPROT, 0);
        chk("arst_rready", RREADY, 0);
        chk("arst_rsp_valid", rsp_valid, 0);
        chk("arst_rsp_data", rsp_data, 0);
        chk("arst_rsp_resp", rsp_resp, 0);
        chk("arst_inflight", inflight, 0);
        chk("arst_busy", busy, 0);
        tick();
        tick();
        #3 ARESETn = 1'b1;
        tick();
        chk("post_inflight", inflight, 0);
        chk("post_rsp_valid", rsp_valid, 0);
        chk("post_rready", RREADY, 1);
        chk("post_arvalid", ARVALID, 0);
        ARREADY = 1'b1;
        req_valid = 1'b1; req_addr = 32'h4000; req_prot = 3'd2;
        #1 chk("post_req_ready", req_ready, 1);
        tick();
        req_valid = 1'b0;
        chk("post_araddr", ARADDR, 32'h4000);
        chk("post_arprot", ARPROT, 3'd2);
        tick();
        RVALID = 1'b1; RDATA = 32'h77; RRESP = 2'd0; tick();
        RVALID = 1'b0;
        chk("post_rsp_valid1", rsp_valid, 1);
        chk("post_rsp_data", rsp_data, 32'h77);
        rsp_ready = 1'b1; tick();
        rsp_ready = 1'b0;
        chk("post_inflight_0", inflight, 0);
        chk("post_idle", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
